// File: rtl/mod_counter.sv
// ============================================================================
//  Module      : mod_counter
//  Description : Modulo counter with programmable limit, up/down, load,
//                wrap/saturate, enable gating and fixed prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter #(
  parameter int N        = 8,
  parameter int PRESCALE = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] limit,
  input  logic         sat,
  output logic [N-1:0] cnt,
  output logic         tc
);

  localparam int c_pre_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic         w_step;
  logic         w_at_term;
  logic [N-1:0] cnt_d, cnt_q;
  logic         tc_d, tc_q;

  generate
    if (PRESCALE > 1) begin : g_prescaler
      logic [c_pre_w-1:0] pre_d, pre_q;

      assign w_step = en & (pre_q == c_pre_w'(PRESCALE - 1));

      always_comb begin
        pre_d = pre_q;
        if (load) begin
          pre_d = '0;
        end else if (en) begin
          pre_d = w_step ? '0 : pre_q + c_pre_w'(1);
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end
    end else begin : g_no_prescaler
      assign w_step = en;
    end
  endgenerate

  // ">=" rather than "==" so a count stranded above a lowered limit still wraps.
  assign w_at_term = up ? (cnt_q >= limit) : (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (load) begin
      cnt_d = (load_val > limit) ? limit : load_val;
    end else if (w_step) begin
      if (w_at_term) begin
        tc_d = 1'b1;
        if (!sat) begin
          cnt_d = up ? '0 : limit;
        end
      end else begin
        cnt_d = up ? cnt_q + N'(1) : cnt_q - N'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
//  Module      : tb_mod_counter
//  Description : Scoreboard bench for mod_counter (PRESCALE=1 and PRESCALE=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic       sat;
  logic [3:0] cnt_a, cnt_b;
  logic       tc_a, tc_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         id;
    int         dut;
    logic [3:0] c;
    logic       t;
  } exp_t;

  exp_t sbq[$];
  int   tag = 0;

  always #5 clock = ~clock;

  mod_counter #(.N(4), .PRESCALE(1)) dut_a (
    .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .sat(sat), .cnt(cnt_a), .tc(tc_a)
  );

  mod_counter #(.N(4), .PRESCALE(3)) dut_b (
    .clock(clock), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .limit(limit), .sat(sat), .cnt(cnt_b), .tc(tc_b)
  );

  // Monitor: outputs settle after the posedge, so compare on the negedge.
  always @(negedge clock) begin
    if (sbq.size() > 0) begin
      exp_t       e;
      logic [3:0] ac;
      logic       at;
      e  = sbq.pop_front();
      ac = (e.dut == 0) ? cnt_a : cnt_b;
      at = (e.dut == 0) ? tc_a  : tc_b;
      n_cmp = n_cmp + 2;
      if (ac !== e.c) begin
        n_bad = n_bad + 1;
        $display("FAIL cnt#%0d dut%0d: got %0d expected %0d", e.id, e.dut, ac, e.c);
      end
      if (at !== e.t) begin
        n_bad = n_bad + 1;
        $display("FAIL tc#%0d dut%0d: got %0b expected %0b", e.id, e.dut, at, e.t);
      end
    end
  end

  task automatic tick(input int dut, input int c, input int t);
    exp_t e;
    @(posedge clock);
    tag   = tag + 1;
    e.id  = tag;
    e.dut = dut;
    e.c   = 4'(c);
    e.t   = t[0];
    sbq.push_back(e);
    #1;
  endtask

  task automatic tick_nc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int dut);
    reset = 1'b1;
    tick(dut, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
    load_val = 4'd0; limit = 4'd9; sat = 1'b0;
    #1;

    // Wrap up to 9: 1..9,0,1,2 with tc on the 0.
    do_reset(0);
    en = 1'b1;
    for (int k = 1; k <= 9; k++) tick(0, k, 0);
    tick(0, 0, 1);
    tick(0, 1, 0);
    tick(0, 2, 0);

    // Saturate: climbs to 9 and holds with tc on every terminal step.
    en = 1'b0; sat = 1'b1;
    do_reset(0);
    en = 1'b1;
    for (int k = 1; k <= 9; k++) tick(0, k, 0);
    tick(0, 9, 1);
    tick(0, 9, 1);
    tick(0, 9, 1);
    en = 1'b0;
    tick(0, 9, 0);

    // Down wrap, limit=5: 5,4,3,2,1,0,5.
    sat = 1'b0; up = 1'b0; limit = 4'd5;
    do_reset(0);
    en = 1'b1;
    tick(0, 5, 1);
    for (int k = 4; k >= 0; k--) tick(0, k, 0);
    tick(0, 5, 1);

    // Load clamps to limit; load beats a terminal step.
    up = 1'b1; limit = 4'd9; load = 1'b1; load_val = 4'd12;
    tick(0, 9, 0);
    load_val = 4'd3;
    tick(0, 3, 0);
    load = 1'b0;
    tick(0, 4, 0);

    // Reset mid-count overrides load and enable.
    load = 1'b1; load_val = 4'd7;
    tick(0, 7, 0);
    reset = 1'b1;
    tick(0, 0, 0);
    reset = 1'b0;

    // Limit lowered below cnt: up wraps with tc, down decrements.
    load_val = 4'd6;
    tick(0, 6, 0);
    load = 1'b0; limit = 4'd3;
    tick(0, 0, 1);
    limit = 4'd9; load = 1'b1;
    tick(0, 6, 0);
    load = 1'b0; limit = 4'd3; up = 1'b0;
    tick(0, 5, 0);

    // limit=0: count pinned at 0, tc on every step in all modes.
    limit = 4'd0; up = 1'b1;
    tick(0, 0, 1);
    tick(0, 0, 1);
    up = 1'b0;
    tick(0, 0, 1);
    sat = 1'b1;
    tick(0, 0, 1);
    up = 1'b1;
    tick(0, 0, 1);

    // Prescaler of 3: step every third enabled cycle; en low freezes phase.
    sat = 1'b0; limit = 4'd15; up = 1'b1; en = 1'b0;
    do_reset(1);
    en = 1'b1;
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 1, 0);
    tick(1, 1, 0);
    tick(1, 1, 0);
    tick(1, 2, 0);
    tick(1, 2, 0);
    en = 1'b0;
    tick(1, 2, 0);
    tick(1, 2, 0);
    en = 1'b1;
    tick(1, 2, 0);
    tick(1, 3, 0);

    // Prescaled wrap at limit=1 with load clearing the phase.
    limit = 4'd1; load = 1'b1; load_val = 4'd1;
    tick(1, 1, 0);
    load = 1'b0;
    tick(1, 1, 0);
    tick(1, 1, 0);
    tick(1, 0, 1);
    tick(1, 0, 0);

    tick_nc();
    for (int w = 0; w < 10 && sbq.size() > 0; w++) tick_nc();
    if (sbq.size() > 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo counter, the next-generation counter primitive for the sequential examples library. It supports a programmable count limit, up/down direction, parallel load, wrap or saturate mode, enable gating and a fixed prescaler, and it flags terminal count with a one-cycle pulse. It drives timers, baud/tick generators and loop counters anywhere a plain free-running counter is insufficient.

## Interface
- N, default 8: counter width in bits; N ≥ 1.
- PRESCALE, default 1: number of enabled cycles per count step; PRESCALE ≥ 1; 1 means every enabled cycle steps.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- en  in  1  count enable; prescaler and counter hold while low.
- up  in  1  direction: 1 counts up, 0 counts down; sampled on each step.
- load  in  1  synchronous parallel load request.
- load_val  in  N  value to load.
- limit  in  N  upper bound; the count range is 0..limit.
- sat  in  1  mode: 1 saturates at the end of range, 0 wraps.
- cnt  out  N  current count, registered.
- tc  out  1  terminal-count pulse, registered, high for one cycle.

## Operation
- Priority per rising edge, highest first: reset > load > step > hold.
- reset: cnt=0, tc=0, prescaler=0.
- load: cnt <= (load_val > limit) ? limit : load_val.
  - Prescaler cleared, tc <= 0.
  - Any step in the same cycle is discarded.
- Prescaler: a PRESCALE-modulo counter, ceil(log2(PRESCALE)) bits, with 0 bits when PRESCALE=1.
  - Increments only when en=1 and load=0.
  - step = en & (prescaler == PRESCALE-1); the prescaler wraps to 0 on step.
  - With PRESCALE=1, step = en.
- Terminal value: when up=1, cnt ≥ limit; when up=0, cnt == 0.
- Step when not at terminal: cnt ± 1, tc <= 0.
- Step when at terminal:
  - Wrap mode (sat=0): up=1 gives cnt <= 0; up=0 gives cnt <= limit.
  - Saturate mode (sat=1): cnt unchanged.
  - Either mode: tc <= 1.
- No step: cnt holds, tc <= 0.
- Arithmetic is unsigned N-bit.
  - cnt never leaves 0..limit except when limit is lowered below cnt at run time.
  - In that case up=1 treats cnt as terminal (wraps to 0, or holds in saturate mode).
  - In that case up=0 decrements normally.
- limit=0: cnt stays 0; every step asserts tc, in either direction and either mode.
- Direction change takes effect on the next step; no extra state.

## Timing
- cnt changes on the rising edge at which the step or load is sampled, giving 1-cycle latency from inputs.
- tc is high during the cycle after a terminal step, aligned with the wrapped or held cnt value.
- Continuous en with PRESCALE=P: one step every P cycles; tc period is (limit+1)·P cycles in wrap mode.
- en low mid-prescale freezes the prescaler phase; stepping resumes where it left off.
- reset asserted mid-count: cnt=0 and tc=0 on the following cycle, regardless of en/load.
- reset or load asserted in the same cycle as a terminal step suppresses tc.
- All outputs are fully registered; there are no combinational paths from inputs to outputs.

## Test plan
- N=4, PRESCALE=1, limit=9, up=1, sat=0, en=1 for 12 cycles after reset -> cnt 1..9,0,1,2; tc high only in the cycle cnt shows 0.
- Same as above with sat=1 -> cnt climbs to 9 and holds; tc high every cycle after the first terminal step while en=1.
- up=0, limit=5, sat=0, from cnt=0 -> cnt 5,4,3,2,1,0,5; tc with the first 5 and again with the second 5.
- PRESCALE=3, limit=15, en=1 -> cnt steps every 3rd cycle; en dropped for 2 cycles after one enabled prescale cycle -> next step is exactly 2 enabled cycles later.
- load=1 with load_val=12, limit=9 -> cnt=9 next cycle, tc=0; load and a terminal step in the same cycle -> load wins, no tc.
- reset asserted while cnt=7, en=1 -> cnt=0, tc=0 next edge; limit lowered from 9 to 3 while cnt=6, up=1, sat=0 -> next step gives cnt=0 with tc=1.
